// File: rtl/miner_scheduler.sv
// Hash-core scheduler: latches work, dispatches nonce ranges to the cores one per
// cycle, aborts stale work, and funnels core hits round-robin into one found pulse.
module miner_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int LOG2_CORES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    work_valid,
  input  logic [639:0]            work,
  input  logic [31:0]             target,
  output logic [639:0]            core_work,
  output logic [31:0]             core_target,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [31:0]             core_nonce,
  output logic                    core_abort,
  input  logic [NUM_CORES-1:0]    core_busy,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [32*NUM_CORES-1:0] core_found_nonce,
  input  logic                    found_ready,
  output logic                    found,
  output logic [31:0]             nonce,
  output logic                    idle,
  output logic [7:0]              drop_count
);

  localparam int KW = (LOG2_CORES > 0) ? LOG2_CORES : 1;

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_RUN, S_ABORT} state_t;

  state_t               r_state, w_state_next;
  logic [KW-1:0]        r_k, w_k_next;
  logic                 r_run_first;
  logic [639:0]         r_work;
  logic [31:0]          r_target;
  logic [NUM_CORES-1:0] r_start, w_start;
  logic [31:0]          r_core_nonce, w_start_nonce;
  logic                 r_abort, w_abort;
  logic                 r_idle;
  logic                 w_clear;

  logic [NUM_CORES-1:0] r_pending, w_pending_next;
  logic [31:0]          r_stored [NUM_CORES];
  logic [31:0]          w_found_nonce [NUM_CORES];
  logic [NUM_CORES-1:0] w_drop_vec;
  logic [8:0]           w_drop_sum;
  logic [7:0]           r_drop;
  logic                 r_found;
  logic [31:0]          r_nonce;
  logic                 r_holdoff;
  logic [KW-1:0]        r_rr, w_idx, w_grant_idx;
  logic                 w_grant;
  logic [NUM_CORES-1:0] w_grant_vec;

  assign core_work   = r_work;
  assign core_target = r_target;
  assign core_start  = r_start;
  assign core_nonce  = r_core_nonce;
  assign core_abort  = r_abort;
  assign found       = r_found;
  assign nonce       = r_nonce;
  assign idle        = r_idle;
  assign drop_count  = r_drop;

  // Each core owns the top LOG2_CORES bits of the nonce space.
  assign w_start_nonce = 32'(r_k) << (32 - LOG2_CORES);

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_clear      = 1'b0;
    w_start      = '0;
    w_abort      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (work_valid) begin
          w_clear      = 1'b1;
          w_state_next = S_DISPATCH;
          w_k_next     = '0;
        end
      end
      S_DISPATCH: begin
        if (work_valid) begin
          w_clear      = 1'b1;
          w_state_next = S_ABORT;
        end else begin
          w_start = NUM_CORES'(1) << r_k;
          if (int'(r_k) == NUM_CORES - 1) begin
            w_state_next = S_RUN;
            w_k_next     = '0;
          end else begin
            w_k_next = r_k + KW'(1);
          end
        end
      end
      S_RUN: begin
        if (work_valid) begin
          w_clear      = 1'b1;
          w_state_next = S_ABORT;
        end else if (!r_run_first && core_busy == '0) begin
          w_state_next = S_IDLE;
        end
      end
      S_ABORT: begin
        w_abort      = 1'b1;
        w_state_next = S_DISPATCH;
        w_k_next     = '0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Round-robin grant; suppressed while a work change is wiping the pending bits.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    w_grant_vec = '0;
    w_idx       = '0;
    if (found_ready && !r_holdoff && !w_clear && (|r_pending)) begin
      for (int off = 0; off < NUM_CORES; off++) begin
        w_idx = r_rr + KW'(off);
        if (!w_grant && r_pending[w_idx]) begin
          w_grant            = 1'b1;
          w_grant_idx        = w_idx;
          w_grant_vec[w_idx] = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign w_found_nonce[gi]  = core_found_nonce[32*gi +: 32];
      assign w_pending_next[gi] = w_clear ? 1'b0 :
                                  core_found[gi] ? 1'b1 :
                                  w_grant_vec[gi] ? 1'b0 : r_pending[gi];
      assign w_drop_vec[gi]     = !w_clear && core_found[gi] && r_pending[gi] && !w_grant_vec[gi];

      always_ff @(posedge clock) begin
        if (reset) begin
          r_stored[gi] <= '0;
        end else if (core_found[gi] && !w_clear) begin
          r_stored[gi] <= w_found_nonce[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    w_drop_sum = {1'b0, r_drop};
    for (int i = 0; i < NUM_CORES; i++) begin
      w_drop_sum = w_drop_sum + 9'(w_drop_vec[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_run_first  <= 1'b0;
      r_work       <= '0;
      r_target     <= '0;
      r_start      <= '0;
      r_core_nonce <= '0;
      r_abort      <= 1'b0;
      r_idle       <= 1'b1;
      r_pending    <= '0;
      r_drop       <= '0;
      r_found      <= 1'b0;
      r_nonce      <= '0;
      r_holdoff    <= 1'b0;
      r_rr         <= '0;
    end else begin
      r_state     <= w_state_next;
      r_k         <= w_k_next;
      r_run_first <= (w_state_next == S_RUN) && (r_state != S_RUN);
      if (work_valid) begin
        r_work   <= work;
        r_target <= target;
      end
      r_start      <= w_start;
      r_core_nonce <= (|w_start) ? w_start_nonce : 32'd0;
      r_abort      <= w_abort;
      r_idle       <= (r_state == S_IDLE);
      r_pending    <= w_pending_next;
      r_drop       <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
      r_found      <= w_grant;
      r_holdoff    <= w_grant;
      if (w_grant) begin
        r_nonce <= r_stored[w_grant_idx];
        r_rr    <= (NUM_CORES == 1) ? '0 : w_grant_idx + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_miner_scheduler.sv
// Directed bench for miner_scheduler (4 cores): dispatch, grace/busy, abort,
// round-robin found arbitration, drop counting and saturation, mid-dispatch reset.
module tb_miner_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic         work_valid;
  logic [639:0] work;
  logic [31:0]  target;
  logic [639:0] core_work;
  logic [31:0]  core_target;
  logic [3:0]   core_start;
  logic [31:0]  core_nonce;
  logic         core_abort;
  logic [3:0]   core_busy;
  logic [3:0]   core_found;
  logic [127:0] core_found_nonce;
  logic         found_ready;
  logic         found;
  logic [31:0]  nonce;
  logic         idle;
  logic [7:0]   drop_count;

  int total = 0;
  int bad   = 0;

  logic [639:0] w1, w2, w3;
  logic [31:0]  start_nonce [4];

  always #5 clock = ~clock;

  miner_scheduler #(.NUM_CORES(4), .LOG2_CORES(2)) dut (
    .clock(clock), .reset(reset), .work_valid(work_valid), .work(work), .target(target),
    .core_work(core_work), .core_target(core_target), .core_start(core_start),
    .core_nonce(core_nonce), .core_abort(core_abort), .core_busy(core_busy),
    .core_found(core_found), .core_found_nonce(core_found_nonce),
    .found_ready(found_ready), .found(found), .nonce(nonce), .idle(idle),
    .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    w1 = {20{32'hA5A5_0001}};
    w2 = {20{32'h5A5A_0002}};
    w3 = {20{32'h1234_0003}};
    start_nonce[0] = 32'h0000_0000;
    start_nonce[1] = 32'h4000_0000;
    start_nonce[2] = 32'h8000_0000;
    start_nonce[3] = 32'hC000_0000;

    reset = 1'b1; work_valid = 1'b0; work = '0; target = '0;
    core_busy = '0; core_found = '0; core_found_nonce = '0; found_ready = 1'b0;
    tick(); tick();
    chk("rst_idle", 640'(idle), 640'(1));
    chk("rst_start", 640'(core_start), 640'(0));
    chk("rst_abort", 640'(core_abort), 640'(0));
    chk("rst_found", 640'(found), 640'(0));
    chk("rst_nonce", 640'(nonce), 640'(0));
    chk("rst_drop", 640'(drop_count), 640'(0));
    chk("rst_work", core_work, 640'(0));
    chk("rst_cnonce", 640'(core_nonce), 640'(0));
    reset = 1'b0;
    tick();

    // Fresh work: dispatch walk
    work_valid = 1'b1; work = w1; target = 32'h0000_FFFF;
    tick();
    work_valid = 1'b0;
    chk("latch_work", core_work, w1);
    chk("latch_target", 640'(core_target), 640'(32'h0000_FFFF));
    chk("idle_T0", 640'(idle), 640'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("start_k%0d", k), 640'(core_start), 640'(4'b0001 << k));
      chk($sformatf("cnonce_k%0d", k), 640'(core_nonce), 640'(start_nonce[k]));
      chk($sformatf("idle_k%0d", k), 640'(idle), 640'(0));
    end
    tick();  // grace edge sees busy=0 and must ignore it
    chk("grace_start", 640'(core_start), 640'(0));
    core_busy = 4'hF;
    tick();
    chk("run_idle0", 640'(idle), 640'(0));
    tick();
    chk("run_idle1", 640'(idle), 640'(0));
    core_busy = 4'h0;
    tick();
    chk("exhaust_idle0", 640'(idle), 640'(0));
    tick();
    chk("exhaust_idle1", 640'(idle), 640'(1));
    chk("exhaust_abort", 640'(core_abort), 640'(0));

    // Cores 1 and 3 hit together
    found_ready = 1'b1;
    core_found = 4'b1010;
    core_found_nonce[32 +: 32] = 32'h11;
    core_found_nonce[96 +: 32] = 32'h33;
    tick();
    core_found = 4'b0000;
    chk("rr_T0_found", 640'(found), 640'(0));
    tick();
    chk("rr_T1_found", 640'(found), 640'(1));
    chk("rr_T1_nonce", 640'(nonce), 640'(32'h11));
    tick();
    chk("rr_T2_holdoff", 640'(found), 640'(0));
    tick();
    chk("rr_T3_found", 640'(found), 640'(1));
    chk("rr_T3_nonce", 640'(nonce), 640'(32'h33));
    tick();
    chk("rr_T4_found", 640'(found), 640'(0));

    // rr_ptr back at 0: core 0 beats core 3
    core_found = 4'b1001;
    core_found_nonce[0 +: 32]  = 32'hA0;
    core_found_nonce[96 +: 32] = 32'hA3;
    tick();
    core_found = 4'b0000;
    tick();
    chk("rr0_first", 640'(nonce), 640'(32'hA0));
    tick(); tick();
    chk("rr0_second_f", 640'(found), 640'(1));
    chk("rr0_second", 640'(nonce), 640'(32'hA3));
    tick();

    // Core 2 overwritten before grant
    found_ready = 1'b0;
    core_found = 4'b0100; core_found_nonce[64 +: 32] = 32'hA;
    tick();
    core_found_nonce[64 +: 32] = 32'hB;
    tick();
    core_found = 4'b0000;
    tick();
    chk("drop_one", 640'(drop_count), 640'(1));
    chk("drop_nofound", 640'(found), 640'(0));
    found_ready = 1'b1;
    tick();
    chk("drop_grant_f", 640'(found), 640'(1));
    chk("drop_grant_n", 640'(nonce), 640'(32'hB));
    tick();

    // Mid-RUN new work with core 0 pending
    found_ready = 1'b0;
    work_valid = 1'b1; work = w2;
    tick();
    work_valid = 1'b0;
    tick(); tick(); tick(); tick();
    core_busy = 4'hF;
    tick();
    core_found = 4'b0001; core_found_nonce[0 +: 32] = 32'h55;
    tick();
    core_found = 4'b0000;
    found_ready = 1'b1;
    work_valid = 1'b1; work = w3;
    tick();
    work_valid = 1'b0;
    chk("abort_latch", core_work, w3);
    chk("abort_T0_found", 640'(found), 640'(0));
    tick();
    chk("abort_pulse", 640'(core_abort), 640'(1));
    chk("abort_T1_found", 640'(found), 640'(0));
    tick();
    chk("abort_done", 640'(core_abort), 640'(0));
    chk("redisp_k0", 640'(core_start), 640'(4'b0001));
    chk("redisp_found", 640'(found), 640'(0));
    core_busy = 4'h0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("redisp_k%0d", k), 640'(core_start), 640'(4'b0001 << k));
      chk($sformatf("redisp_nf%0d", k), 640'(found), 640'(0));
    end
    tick(); tick(); tick();
    chk("redisp_idle", 640'(idle), 640'(1));
    chk("redisp_nofound", 640'(found), 640'(0));

    // Saturation: 300 hits on core 1 without a grant
    found_ready = 1'b0;
    core_found = 4'b0010;
    for (int i = 0; i < 300; i++) begin
      core_found_nonce[32 +: 32] = 32'(i);
      tick();
    end
    core_found = 4'b0000;
    chk("sat_drop", 640'(drop_count), 640'(255));
    found_ready = 1'b1;
    tick();
    chk("sat_found", 640'(found), 640'(1));
    chk("sat_nonce", 640'(nonce), 640'(32'd299));
    tick();

    // Reset while dispatching k=2
    work_valid = 1'b1; work = w1;
    tick();
    work_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_k2", 640'(core_start), 640'(4'b0100));
    reset = 1'b1;
    tick();
    chk("mrst_start", 640'(core_start), 640'(0));
    chk("mrst_idle", 640'(idle), 640'(1));
    chk("mrst_work", core_work, 640'(0));
    chk("mrst_drop", 640'(drop_count), 640'(0));
    chk("mrst_cnonce", 640'(core_nonce), 640'(0));
    chk("mrst_nonce", 640'(nonce), 640'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_s1", 640'(core_start), 640'(0));
    tick();
    chk("post_rst_s2", 640'(core_start), 640'(0));
    chk("post_rst_idle", 640'(idle), 640'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
